// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer in front of the 128-bit DMEM
// Optional response watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_data_ready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0] state;
    logic       last;
    logic       sel;
    logic       wr;
    logic       pick;
    logic       pick_we;
    logic       timeout;

    // On contention the requester that was not granted last wins.
    always_comb begin
        pick    = (req0 && req1) ? ~last : req1;
        pick_we = pick ? we1 : we0;
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= (state == ST_ACCESS) && !mem_data_ready && timeout;
            if (state == ST_ACCESS && !mem_data_ready)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            last             <= 1'b1;
            sel              <= 1'b0;
            wr               <= 1'b0;
            gnt0             <= 1'b0;
            gnt1             <= 1'b0;
            done0            <= 1'b0;
            done1            <= 1'b0;
            rdata0           <= '0;
            rdata1           <= '0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        sel              <= pick;
                        last             <= pick;
                        wr               <= pick_we;
                        gnt0             <= !pick;
                        gnt1             <= pick;
                        mem_addr         <= pick ? addr1 : addr0;
                        mem_write_data   <= pick ? wdata1 : wdata0;
                        mem_read_enable  <= !pick_we;
                        mem_write_enable <= pick_we;
                        state            <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_data_ready || timeout) begin
                        if (mem_data_ready && !wr) begin
                            if (sel)
                                rdata1 <= mem_read_data;
                            else
                                rdata0 <= mem_read_data;
                        end
                        mem_read_enable  <= 1'b0;
                        mem_write_enable <= 1'b0;
                        done0            <= !sel;
                        done1            <= sel;
                        state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Wait for DMEM to drop ready to close the four-phase handshake.
                    if (!mem_data_ready) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the crypto processor's 128-bit data memory (DMEM). It lets two requesters share the single DMEM access port: requester 0 is the plaintext/key fetch path and requester 1 is the ciphertext write-back path. Each transaction uses a four-phase enable/`data_ready` handshake with DMEM. Requesters receive a registered grant, a one-cycle `done` pulse and captured read data.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, DMEM word address width.
- `DATA_WIDTH`, 128, block width.
- `TIMEOUT_CYCLES`, 64, watchdog limit on DMEM response. Used only with `DMEM_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: transaction request, held until the matching `done`.
- `we0` / `we1` in 1: 1 = write, 0 = read. Sampled with `req` at grant.
- `addr0` / `addr1` in `ADDR_WIDTH`: word address.
- `wdata0` / `wdata1` in `DATA_WIDTH`: write data.
- `gnt0` / `gnt1` out 1: registered grant; at most one high.
- `done0` / `done1` out 1: one-cycle completion pulse.
- `rdata0` / `rdata1` out `DATA_WIDTH`: read data, valid from `done` until the next read by the same requester.
- `err` out 1: qualifies `done`; high = timed-out transaction.
- `mem_read_enable` / `mem_write_enable` out 1: DMEM enables (level).
- `mem_addr` out `ADDR_WIDTH`, `mem_write_data` out `DATA_WIDTH`: DMEM address and write data.
- `mem_read_data` in `DATA_WIDTH`, `mem_data_ready` in 1: DMEM response (level).

## Operation
Reset values:
- All outputs are 0.
- State is IDLE.
- The last-grant pointer is 1, so requester 0 wins the first contention.

FSM:
- **IDLE**
  - No request: stay in IDLE.
  - If any `req` is high, select a winner. When only one requester asserts `req`, it wins; when both do, the requester not recorded as last-granted wins.
  - Register `gnt`, `mem_addr` and `mem_write_data` from the winner's inputs, and set `mem_read_enable = !we` or `mem_write_enable = we`.
  - Update the last-grant pointer, then go to ACCESS.
- **ACCESS**
  - Hold the enables, address and data stable.
  - When `mem_data_ready` is sampled high:
    - on a read, capture `mem_read_data` into the winner's `rdata`;
    - drop both enables and go to RESP.
- **RESP**
  - Enables stay low.
  - The winner's `done` is high for exactly the first RESP cycle.
  - Stay in RESP until `mem_data_ready` is sampled low, then clear `gnt` and go to IDLE. This completes the four-phase handshake.

Rules:
- A write leaves both `rdata` outputs unchanged.
- A requester still holding `req` after `done` is treated as a new transaction. It loses to a pending request from the other requester.
- `req` dropped while granted: the transaction still completes and `done` still pulses.
- Inputs from the non-granted requester are ignored.
- `err` is 0 on every normal completion.

## Timing
- Minimum latency from `req` high at edge E:
  - `gnt` and the mem enable are high after E.
  - With `mem_data_ready` high at E+k, enables are low and `done` is high after E+k (that is, in the cycle following E+k).
  - Arbitration costs 1 cycle; completion costs 1 cycle after ready.
- Back-to-back: the next grant occurs no earlier than 1 cycle after `mem_data_ready` is seen low.
- Asynchronous `rst` at any time (including mid-ACCESS):
  - outputs go to reset values immediately;
  - no `done` pulse;
  - the in-flight transaction is abandoned.

## Configuration
- `DMEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `mem_data_ready` low.
  - When the counter reaches `TIMEOUT_CYCLES`: drop the enables, go to RESP, pulse `done` with `err = 1`, and leave `rdata` unchanged.
  - RESP then exits on `mem_data_ready` low, as in normal operation.
- `DMEM_ARB_TIMEOUT_EN` undefined: ACCESS waits indefinitely, `err` is tied to 0, and no counter logic is built.

## Test plan
- **Single read.** `req0 = 1`, `we0 = 0`, `addr0 = 8'h00`; DMEM asserts ready 3 cycles later with `128'h00112233445566778899aabbccddeeff`. Required: `gnt0` and `mem_read_enable` one cycle after `req0`; one-cycle `done0`; `rdata0` equals that value; `rdata1` stays 0.
- **Single write.** `req1 = 1`, `we1 = 1`, `addr1 = 8'h10`, `wdata1 = 128'hdeadbeef...`. Required: `mem_write_enable = 1`, `mem_addr = 8'h10`, `mem_write_data` matches; `done1` pulse; `rdata1` unchanged.
- **Contention.** `req0` and `req1` rise on the same edge, both held. Required grant order after reset: 0, 1, 0, 1, with exactly four `done` pulses.
- **Reset mid-ACCESS.** `rst` pulsed 2 cycles into a read. Required: all outputs 0 immediately; no `done`; the next request is served normally.
- **Timeout** (with `DMEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES = 8`). DMEM never asserts ready. Required: enables drop after 8 ACCESS cycles; `done0 = 1` and `err = 1` for one cycle; `rdata0` unchanged.
- **Handshake hold.** `mem_data_ready` stays high for 5 cycles after completion. Required: no new grant until it falls, then `gnt` on the cycle after it is sampled low.
